// File: rtl/goldschmidt_div_unit_pkg.sv
// Shared types and helpers for the Goldschmidt divider.
//   gs_state_e : control FSM states
//   gs_tag_e   : which recurrence (D or N) an in-flight product belongs to
//   one_val    : 1.0 in Q1.(w-1)
//   rne_round  : round a Q2.(2w-2) product back to Q1.(w-1), RNE, saturating
package gs_div_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE_D, ISSUE_N, WAIT, FIN, DONE} gs_state_e;
  typedef enum logic {TAG_D, TAG_N} gs_tag_e;

  // Widest operand the helpers support; callers pass the real width.
  localparam int unsigned MAXW = 64;

  function automatic logic [MAXW-1:0] one_val(input int unsigned w);
    return MAXW'(1) << (w - 1);
  endfunction

  // Keep product bits [2w-2:w-1]; guard = bit w-2; sticky = |bits[w-3:0].
  // Result saturates to all ones when bit 2w-1 is set or rounding carries out.
  function automatic logic [MAXW-1:0] rne_round(input logic [2*MAXW-1:0] prod,
                                                input int unsigned w);
    logic [2*MAXW-1:0] one_b;
    logic [MAXW-1:0]   wmask;
    logic [MAXW-1:0]   kept;
    logic [MAXW:0]     inc;
    logic              guard, sticky, ovf, rnd;
    one_b  = (2*MAXW)'(1);
    wmask  = {MAXW{1'b1}} >> (MAXW - w);
    kept   = MAXW'(prod >> (w - 1)) & wmask;
    guard  = |(prod & (one_b << (w - 2)));
    sticky = |(prod & ((one_b << (w - 2)) - one_b));
    ovf    = |(prod & (one_b << (2*w - 1)));
    rnd    = guard & (sticky | kept[0]);
    inc    = {1'b0, kept} + (MAXW+1)'(rnd);
    if (ovf || (|(inc >> w))) return wmask;
    return inc[MAXW-1:0];
  endfunction

endpackage

// File: rtl/goldschmidt_div_unit_if.sv
// Handshake/operand bundle of the Goldschmidt divider.
//   in_valid/in_ready  : operand handshake (n, d, ia, recip)
//   out_valid/out_ready: result handshake (q, err)
// master = producer/consumer side, slave = divider side.
interface goldschmidt_div_unit_if #(parameter int unsigned WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] ia;
  logic             recip;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             err;

  modport master (output in_valid, n, d, ia, recip, out_ready,
                  input  in_ready, out_valid, q, err);
  modport slave  (input  in_valid, n, d, ia, recip, out_ready,
                  output in_ready, out_valid, q, err);
endinterface

// File: rtl/goldschmidt_div_unit_mul.sv
// Two-stage pipelined multiplier with RNE rounding, carrying a valid bit and
// a D/N tag alongside the operands.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   issue_i/tag_i/a_i/b_i : operand pair issued in cycle t
//   vld_o/tag_o/res_o     : rounded product visible in cycle t+2
module gs_mul_pipe
  import gs_div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_i,
  input  gs_tag_e          tag_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             vld_o,
  output gs_tag_e          tag_o,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH-1:0]   a_q, b_q;
  logic               v1_q, v2_q;
  gs_tag_e            tag1_q, tag2_q;
  logic [2*WIDTH-1:0] prod_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      v1_q   <= 1'b0;
      tag1_q <= TAG_D;
      prod_q <= '0;
      v2_q   <= 1'b0;
      tag2_q <= TAG_D;
    end else begin
      a_q    <= a_i;
      b_q    <= b_i;
      v1_q   <= issue_i;
      tag1_q <= tag_i;
      prod_q <= (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
      v2_q   <= v1_q;
      tag2_q <= tag1_q;
    end
  end

  assign vld_o = v2_q;
  assign tag_o = tag2_q;
  assign res_o = WIDTH'(rne_round((2*MAXW)'(prod_q), WIDTH));

endmodule

// File: rtl/goldschmidt_div_unit.sv
// Self-sequencing Goldschmidt divider, q = n/d (or 1/d when recip=1).
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : operand/result handshake (slave side)
// Each iteration issues D*K then N*K into one shared multiplier and waits a
// cycle; the D result refreshes K = 2 - D'.
module goldschmidt_div_unit
  import gs_div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  goldschmidt_div_unit_if.slave bus
);

  localparam int unsigned      CW  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(one_val(WIDTH));

  gs_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q, err_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] n_q, d_q, k_q;
  logic [WIDTH-1:0] n_d, d_d, k_d;

  logic             accept;
  logic             mul_issue, mul_vld;
  gs_tag_e          mul_tag_in, mul_tag;
  logic [WIDTH-1:0] mul_a, mul_res;

  assign accept     = bus.in_valid && (state_q == IDLE);
  assign mul_issue  = (state_q == ISSUE_D) || (state_q == ISSUE_N);
  assign mul_tag_in = (state_q == ISSUE_N) ? TAG_N : TAG_D;
  assign mul_a      = (state_q == ISSUE_N) ? n_q : d_q;

  gs_mul_pipe #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk),
    .rst_ni  (reset),
    .issue_i (mul_issue),
    .tag_i   (mul_tag_in),
    .a_i     (mul_a),
    .b_i     (k_q),
    .vld_o   (mul_vld),
    .tag_o   (mul_tag),
    .res_o   (mul_res)
  );

  // Accept and writeback never coincide: the pipeline is empty in IDLE.
  always_comb begin
    n_d = n_q;
    d_d = d_q;
    k_d = k_q;
    if (accept) begin
      n_d = bus.recip ? ONE : bus.n;
      d_d = bus.d;
      k_d = bus.ia;
    end
    if (mul_vld) begin
      if (mul_tag == TAG_D) begin
        d_d = mul_res;
        k_d = ~mul_res + WIDTH'(1);
      end else begin
        n_d = mul_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      n_q <= '0;
      d_q <= '0;
      k_q <= '0;
    end else begin
      n_q <= n_d;
      d_q <= d_d;
      k_q <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (!bus.d[WIDTH-1]) begin
              state_q     <= DONE;
              q_q         <= '1;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ISSUE_D;
            end
          end
        end
        ISSUE_D: state_q <= ISSUE_N;
        ISSUE_N: state_q <= WAIT;
        WAIT: begin
          if (cnt_q < CW'(ITER - 1)) begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= ISSUE_D;
          end else begin
            state_q <= FIN;
          end
        end
        FIN: begin
          // Final N' lands on this same edge, so take the bypassed value.
          state_q     <= DONE;
          q_q         <= n_d;
          err_q       <= 1'b0;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_goldschmidt_div_unit.sv
// Scoreboard bench for goldschmidt_div_unit (WIDTH=16, ITER=3).
module tb_goldschmidt_div_unit;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  goldschmidt_div_unit_if #(.WIDTH(W)) bus ();

  goldschmidt_div_unit #(.WIDTH(W), .ITER(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_ops(input logic [W-1:0] nv, input logic [W-1:0] dv,
                         input logic [W-1:0] iav, input logic rv);
    bus.n     = nv;
    bus.d     = dv;
    bus.ia    = iav;
    bus.recip = rv;
  endtask

  task automatic scramble_ops();
    bus.n     = W'($urandom);
    bus.d     = W'($urandom);
    bus.ia    = W'($urandom);
    bus.recip = 1'($urandom);
  endtask

  // Called at a negedge; presents one op and pushes its expectation.
  task automatic drive(input logic [W-1:0] nv, input logic [W-1:0] dv,
                       input logic [W-1:0] iav, input logic rv,
                       input logic [W-1:0] eq, input logic ee, input int el);
    exp_t e;
    int   k;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    set_ops(nv, dv, iav, rv);
    bus.in_valid = 1'b1;
    e.q = eq; e.err = ee; e.lat = el; e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_ops();
  endtask

  // Waits for a result, checks it, then holds it for 'hold' cycles.
  task automatic collect(input int hold);
    exp_t e;
    int   k;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      chk("q", 32'(bus.q), 32'(e.q));
      chk("err", 32'(bus.err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_q", 32'(bus.q), 32'(e.q));
        chk("hold_err", 32'(bus.err), 32'(e.err));
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("rel_valid", 32'(bus.out_valid), 32'd0);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   seen;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_ops('0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // 1.5 / 1.0
    drive(16'hC000, 16'h8000, 16'h8000, 1'b0, 16'hC000, 1'b0, 11);
    collect(0); release_out();
    // 1.0 / 1.5 with K0 ~ 2/3
    drive(16'h8000, 16'hC000, 16'h5555, 1'b0, 16'h5555, 1'b0, 11);
    collect(0); release_out();
    // reciprocal of 1.0, n ignored
    drive(16'h1234, 16'h8000, 16'h8000, 1'b1, 16'h8000, 1'b0, 11);
    collect(0); release_out();
    // unnormalised divisors
    drive(16'hC000, 16'h4000, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1);
    collect(0); release_out();
    drive(16'h8000, 16'h0000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1);
    collect(0); release_out();
    // largest dividend over 1.0
    drive(16'hFFFF, 16'h8000, 16'h8000, 1'b0, 16'hFFFF, 1'b0, 11);
    collect(0); release_out();
    // largest divisor, K0 = 0.5
    drive(16'h8000, 16'hFFFF, 16'h4000, 1'b0, 16'h4000, 1'b0, 11);
    collect(0); release_out();

    // Backpressure, then a new op presented in the same cycle out_ready rises
    drive(16'h8000, 16'hC000, 16'h5555, 1'b0, 16'h5555, 1'b0, 11);
    collect(5);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_ops(16'h1234, 16'h8000, 16'h8000, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("b2b_valid", 32'(bus.out_valid), 32'd0);
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    e.q = 16'h8000; e.err = 1'b0; e.lat = 11; e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_ops();
    chk("b2b_accepted", 32'(bus.in_ready), 32'd0);
    collect(0); release_out();

    // Reset in the middle of an operation
    drive(16'hC000, 16'h8000, 16'h8000, 1'b0, 16'hC000, 1'b0, 11);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_q", 32'(bus.q), 32'd0);
    reset = 1'b1;
    void'(sb.pop_front());
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_output", 32'(seen), 32'd0);
    drive(16'hC000, 16'h8000, 16'h8000, 1'b0, 16'hC000, 1'b0, 11);
    collect(0); release_out();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/goldschmidt_div_unit.md
Name: goldschmidt_div_unit

Overview:
- Parametrised, self-sequencing Goldschmidt divider. Successor to the fixed 16-bit, externally sequenced divide datapath.
- Contains its own control FSM and iteration counter.
- Time-multiplexes one pipelined multiplier with round-to-nearest-even (RNE) across the D and N updates.
- Adds a valid/ready handshake on input and output, a reciprocal mode, and unnormalised-divisor detection. Sits between operand normalisation and result packing in the FP divide path.

Parameters:
- WIDTH, 16, operand/result width; unsigned fixed point Q1.(WIDTH-1), 1.0 = 1<<(WIDTH-1).
- ITER, 3, Goldschmidt iterations per operation (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept; = (state==IDLE).
- n  input  WIDTH  dividend, Q1.(WIDTH-1).
- d  input  WIDTH  divisor, Q1.(WIDTH-1), must satisfy d[WIDTH-1]=1 (d in [1,2)).
- ia  input  WIDTH  initial reciprocal approximation K0 of 1/d.
- recip  input  1  1 = compute 1/d (n ignored, treated as 1.0).
- out_valid  output  1  q/err valid.
- out_ready  input  1  consumer accepts result.
- q  output  WIDTH  quotient, Q1.(WIDTH-1).
- err  output  1  divisor unnormalised; q saturated.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, out_valid=0, q=0, err=0, pipeline valid bits=0, iteration counter=0.
  - Applies mid-operation too: any in-flight op is discarded with no output.
- Accept:
  - Accept occurs in cycle a when in_valid & in_ready.
  - Registers load: N_r = recip ? 1.0 : n; D_r = d; K_r = ia; cnt = 0.
- Error path:
  - If d[WIDTH-1]==0 at accept: next state DONE, q = all ones, err = 1.
  - out_valid is asserted in cycle a+1.
- Multiplier (gs_mul_pipe):
  - Stage 1 registers operand pair plus a tag (D or N) and a valid bit.
  - Stage 2 registers the 2*WIDTH-bit product, tag and valid bit.
  - The rounded result is combinational from stage 2, so an operand pair issued in cycle t is visible in cycle t+2.
- RNE rounding:
  - Product is Q2.(2W-2). Keep bits [2W-2:W-1]; guard = bit W-2; sticky = OR of bits [W-3:0].
  - Increment when guard & (sticky | lsb).
  - Saturate to all ones if bit 2W-1 is set or the increment overflows.
- FSM states:
  - IDLE -> ISSUE_D (or DONE on error).
  - ISSUE_D (issue D_r*K_r) -> ISSUE_N.
  - ISSUE_N (issue N_r*K_r) -> WAIT.
  - WAIT -> ISSUE_D if cnt<ITER-1 (cnt++), else -> FIN.
  - FIN -> DONE.
  - DONE -> IDLE when out_ready.
- Writeback:
  - When a stage-2 valid result has tag D: D_r <= rounded; K_r <= ~rounded + 1 (2 - D' in WIDTH-bit two's complement).
  - When it has tag N: N_r <= rounded.
  - With 3 cycles per iteration, the N' writeback coincides with the next ISSUE_D. No conflict: ISSUE_D reads only D_r/K_r, which were updated the cycle before.
- Latency (normal op):
  - Last N' is written at the end of cycle a+3*ITER+1.
  - out_valid=1 in cycle a+3*ITER+2 (11 cycles for ITER=3).
  - q = N_r and err = 0 are registered on entry to DONE.
- Output hold:
  - In DONE, q, err and out_valid are held stable while out_ready=0.
  - On out_ready, out_valid drops next cycle and in_ready rises (state IDLE).
  - No new accept while DONE, even if out_ready=1 in the same cycle. Throughput is one op per latency+1 cycles.
- in_valid outside IDLE is ignored. Operand inputs are sampled only at accept.
- d = 1.0 with ia = 1.0 converges exactly (K=1.0 every iteration).

Decomposition:
- Package gs_div_pkg:
  - state enum (IDLE, ISSUE_D, ISSUE_N, WAIT, FIN, DONE).
  - tag enum (TAG_D, TAG_N).
  - function rne_round(product, WIDTH).
  - localparam ONE = 1<<(WIDTH-1) helper.
- Sub-module gs_mul_pipe: 2-stage multiply plus RNE carrying valid/tag, parameter WIDTH.
- Top-level contents: FSM, counter, N/D/K registers, handshake.

Test Plan:
- WIDTH=16, ITER=3: accept n=0xC000, d=0x8000, ia=0x8000 at cycle a -> out_valid first high at a+11, q=0xC000, err=0.
- n=0x8000, d=0xC000, ia=0x5555 -> q within 1 ulp of 0x5555, err=0, latency 11.
- recip=1, n=0x1234 (ignored), d=0x8000, ia=0x8000 -> q=0x8000.
- d=0x4000 (unnormalised) -> out_valid at a+1, q=0xFFFF, err=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> q/err/out_valid stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle, and back-to-back in_valid is accepted then.
- Reset mid-op: drive reset=0 at a+5 -> next cycle out_valid=0, in_ready=1, pipeline empty. A following op (n=0xC000, d=0x8000, ia=0x8000) returns 0xC000 at the correct latency.
